// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Parametrised Fibonacci LFSR with reseed, lock-up guard and optional wrap detect (LFSR_WRAP_DETECT_EN)
module lfsr_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hB400),
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             seed_load_in,
    input  logic             step_in,
    output logic [WIDTH-1:0] q_out,
    output logic             valid_out,
    output logic             wrap_out
);

    // Per-cycle action; reset is handled directly in the register process.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_ADVANCE,
        OP_LOAD,
        OP_RECOVER
    } op_t;

    op_t              op;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] guarded_seed;
    logic             valid_q;

    // One shift of the Fibonacci register: feedback enters at bit 0.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // A zero seed would lock the register, so substitute the default.
    assign guarded_seed = (seed_in == '0) ? DEFAULT_SEED : seed_in;

    // Unrolled STEPS shifts so the register advances several positions per cycle.
    always_comb begin
        stepped = state_q;
        for (int s = 0; s < STEPS; s++) begin
            stepped = lfsr_step(stepped);
        end
    end

    // Choose this cycle's action: load beats lock-up recovery beats step beats hold.
    always_comb begin
        op = OP_HOLD;
        if (seed_load_in) begin
            op = OP_LOAD;
        end else if (state_q == '0) begin
            op = OP_RECOVER;
        end else if (step_in) begin
            op = OP_ADVANCE;
        end
    end

    // State register and the one-cycle valid pulse for every load or advance.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= guarded_seed;
            valid_q <= 1'b0;
        end else begin
            case (op)
                OP_LOAD: begin
                    state_q <= guarded_seed;
                    valid_q <= 1'b1;
                end
                OP_RECOVER: begin
                    state_q <= DEFAULT_SEED;
                    valid_q <= 1'b1;
                end
                OP_ADVANCE: begin
                    state_q <= stepped;
                    valid_q <= 1'b1;
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign q_out     = state_q;
    assign valid_out = valid_q;

`ifdef LFSR_WRAP_DETECT_EN
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] step_cnt_q;
    logic             wrap_q;

    // Remember the last loaded seed and flag any advance that lands back on it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            seed_q     <= guarded_seed;
            step_cnt_q <= '0;
            wrap_q     <= 1'b0;
        end else begin
            case (op)
                OP_LOAD: begin
                    seed_q     <= guarded_seed;
                    step_cnt_q <= '0;
                    wrap_q     <= 1'b0;
                end
                OP_RECOVER: begin
                    seed_q     <= DEFAULT_SEED;
                    step_cnt_q <= '0;
                    wrap_q     <= 1'b0;
                end
                OP_ADVANCE: begin
                    step_cnt_q <= step_cnt_q + WIDTH'(STEPS);
                    wrap_q     <= (stepped == seed_q);
                end
                default: begin
                    wrap_q <= 1'b0;
                end
            endcase
        end
    end

    assign wrap_out = wrap_q;
`else
    assign wrap_out = 1'b0;
`endif

endmodule
